// File: rtl/alu_operand_stage.sv
// Registered operand stage in front of the ALU: captures decoded operands, applies zero-index
// and optional writeback forwarding (ALU_OPERAND_FWD_EN), and hands A/B/ctrl over through a 2-entry skid buffer.
module alu_operand_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [REGW-1:0] rs1_idx,
  input  logic [REGW-1:0] rs2_idx,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  input  logic            alu_src,
  input  logic [2:0]      ctrl_in,
  input  logic [REGW-1:0] rd_in,
  input  logic            fwd_we,
  input  logic [REGW-1:0] fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_ctrl,
  output logic [REGW-1:0] rd_out
);

  typedef struct packed {
    logic [REGW-1:0] rs1_idx;
    logic [REGW-1:0] rs2_idx;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic            alu_src;
    logic [2:0]      ctrl;
    logic [REGW-1:0] rd;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t state_q, state_d;
  logic   in_ready_q;
  entry_t ent_q   [2];
  entry_t ent_d   [2];
  entry_t ent_fwd [2];
  entry_t new_ent;
  logic   accept, consume;

`ifndef ALU_OPERAND_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{fwd_we, fwd_rd, fwd_data};
`endif

  // Operand value for a register index: r0 reads zero, otherwise a matching writeback wins.
  function automatic logic [XLEN-1:0] fwd_op(input logic [REGW-1:0] idx, input logic [XLEN-1:0] val);
    if (idx == '0) return '0;
`ifdef ALU_OPERAND_FWD_EN
    if (fwd_we && (fwd_rd == idx)) return fwd_data;
`endif
    return val;
  endfunction

  function automatic entry_t snoop(input entry_t e);
    entry_t r;
    r   = e;
    r.a = fwd_op(e.rs1_idx, e.a);
    r.b = fwd_op(e.rs2_idx, e.b);
    return r;
  endfunction

  // Index 0 is main (drives the outputs), index 1 is the skid entry.
  for (genvar gi = 0; gi < 2; gi++) begin : g_snoop
    assign ent_fwd[gi] = snoop(ent_q[gi]);
  end

  always_comb begin
    new_ent         = '0;
    new_ent.rs1_idx = rs1_idx;
    new_ent.rs2_idx = rs2_idx;
    new_ent.a       = fwd_op(rs1_idx, rs1_val);
    new_ent.b       = fwd_op(rs2_idx, rs2_val);
    new_ent.imm     = imm;
    new_ent.alu_src = alu_src;
    new_ent.ctrl    = ctrl_in;
    new_ent.rd      = rd_in;
  end

  assign accept  = in_valid && in_ready_q;
  assign consume = (state_q != EMPTY) && out_ready;

  always_comb begin
    state_d  = state_q;
    ent_d[0] = ent_fwd[0];
    ent_d[1] = ent_fwd[1];
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            ent_d[0] = new_ent;
            state_d  = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            ent_d[0] = new_ent;
          end else if (accept) begin
            ent_d[1] = new_ent;
            state_d  = TWO;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            ent_d[0] = ent_fwd[1];
            state_d  = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      for (int i = 0; i < 2; i++) ent_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
      for (int i = 0; i < 2; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign alu_a     = ent_q[0].a;
  assign alu_b     = ent_q[0].alu_src ? ent_q[0].imm : ent_q[0].b;
  assign alu_ctrl  = ent_q[0].ctrl;
  assign rd_out    = ent_q[0].rd;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed scenarios plus randomized traffic checked
// against a queue-based model of accepted-but-not-consumed bundles.
module tb_alu_operand_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  rs1_idx, rs2_idx, rd_in, fwd_rd, rd_out;
  logic [31:0] rs1_val, rs2_val, imm, fwd_data, alu_a, alu_b;
  logic        alu_src, fwd_we, flush, out_valid, out_ready;
  logic [2:0]  ctrl_in, alu_ctrl;

  int checks = 0;
  int errors = 0;

  alu_operand_stage #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .imm(imm), .alu_src(alu_src), .ctrl_in(ctrl_in), .rd_in(rd_in),
    .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: every bundle that has entered and not yet left, oldest first.
  typedef struct {
    logic [4:0]  r1, r2, rd;
    logic [31:0] a, b, imm;
    logic        src;
    logic [2:0]  ctrl;
  } exp_t;
  exp_t q[$];

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
    end else begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, (q.size() != 0)});
      if (q.size() != 0) begin
        e = q[0];
        chk("sb_alu_a", alu_a, e.a);
        chk("sb_alu_b", alu_b, e.src ? e.imm : e.b);
        chk("sb_ctrl", {29'd0, alu_ctrl}, {29'd0, e.ctrl});
        chk("sb_rd", {27'd0, rd_out}, {27'd0, e.rd});
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        e.r1 = rs1_idx; e.r2 = rs2_idx; e.rd = rd_in;
        e.a = (rs1_idx == 0) ? 32'd0 : rs1_val;
        e.b = (rs2_idx == 0) ? 32'd0 : rs2_val;
        e.imm = imm; e.src = alu_src; e.ctrl = ctrl_in;
        q.push_back(e);
      end
`ifdef ALU_OPERAND_FWD_EN
      if (fwd_we && fwd_rd != 0) begin
        foreach (q[i]) begin
          if (q[i].r1 == fwd_rd) q[i].a = fwd_data;
          if (q[i].r2 == fwd_rd) q[i].b = fwd_data;
        end
      end
`endif
      if (flush) q.delete();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; fwd_we = 0; fwd_rd = 0; fwd_data = 0;
  endtask

  task automatic bundle(input logic [4:0] r1, input logic [31:0] v1, input logic [4:0] r2,
                        input logic [31:0] v2, input logic [31:0] im, input logic src,
                        input logic [2:0] c, input logic [4:0] rd);
    in_valid = 1; rs1_idx = r1; rs1_val = v1; rs2_idx = r2; rs2_val = v2;
    imm = im; alu_src = src; ctrl_in = c; rd_in = rd;
  endtask

  initial begin
    rst_n = 0; out_ready = 1;
    idle();
    bundle(0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_ctrl", {29'd0, alu_ctrl}, 32'd0);
    chk("rst_rd", {27'd0, rd_out}, 32'd0);
    step();
    rst_n = 1;
    step();

    // Single bundle, 1-cycle latency
    bundle(1, 5, 2, 7, 32'h1234, 0, 3'b001, 3);
    step(); in_valid = 0;
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_a", alu_a, 32'd5);
    chk("t1_b", alu_b, 32'd7);
    chk("t1_ctrl", {29'd0, alu_ctrl}, 32'd1);
    chk("t1_rd", {27'd0, rd_out}, 32'd3);
    step();
    chk("t1_drain", {31'd0, out_valid}, 32'd0);

    // Immediate select
    bundle(1, 0, 2, 9, 32'hFFFFFFFC, 1, 3'b000, 4);
    step(); in_valid = 0;
    chk("t2_imm_b", alu_b, 32'hFFFFFFFC);
    step();

    // Stall and stream three bundles
    out_ready = 0;
    bundle(1, 1, 0, 0, 0, 0, 3'b010, 1);
    step();
    chk("t3_ready_after1", {31'd0, in_ready}, 32'd1);
    bundle(1, 2, 0, 0, 0, 0, 3'b010, 2);
    step();
    chk("t3_ready_after2", {31'd0, in_ready}, 32'd0);
    bundle(1, 3, 0, 0, 0, 0, 3'b010, 3);
    step(); step();
    chk("t3_hold_a", alu_a, 32'd1);
    chk("t3_hold_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1;
    step();
    chk("t3_second", alu_a, 32'd2);
    step(); in_valid = 0;
    chk("t3_third", alu_a, 32'd3);
    step();
    chk("t3_empty", {31'd0, out_valid}, 32'd0);

    // Zero index always reads zero, even with a matching writeback
    bundle(0, 32'hDEAD, 0, 32'hBEEF, 0, 0, 3'b011, 5);
    fwd_we = 1; fwd_rd = 0; fwd_data = 77;
    step(); idle();
    chk("zero_idx_a", alu_a, 32'd0);
    chk("zero_idx_b", alu_b, 32'd0);
    step();

`ifdef ALU_OPERAND_FWD_EN
    bundle(4, 10, 0, 0, 0, 0, 3'b000, 1);
    fwd_we = 1; fwd_rd = 4; fwd_data = 99;
    step(); idle();
    chk("fwd_capture_a", alu_a, 32'd99);
    step();
    out_ready = 0;
    bundle(0, 0, 6, 1, 0, 0, 3'b000, 2);
    step(); idle();
    fwd_we = 1; fwd_rd = 6; fwd_data = 32'h55;
    step(); idle();
    chk("fwd_snoop_b", alu_b, 32'h55);
    out_ready = 1;
    step();
`endif

    // Flush in TWO together with a new bundle
    out_ready = 0;
    bundle(1, 11, 0, 0, 0, 0, 3'b000, 1); step();
    bundle(1, 12, 0, 0, 0, 0, 3'b000, 2); step();
    bundle(1, 13, 0, 0, 0, 0, 3'b000, 3); flush = 1;
    step(); idle();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1;
    step(); step();
    chk("flush_nothing", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-stall
    out_ready = 0;
    bundle(1, 21, 0, 0, 0, 0, 3'b000, 1); step();
    bundle(1, 22, 0, 0, 0, 0, 3'b000, 2); step();
    in_valid = 0;
    #1 rst_n = 0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    step();
    rst_n = 1; out_ready = 1;
    step();
    bundle(2, 33, 0, 0, 0, 0, 3'b100, 7);
    step(); in_valid = 0;
    chk("arst_fresh_valid", {31'd0, out_valid}, 32'd1);
    chk("arst_fresh_a", alu_a, 32'd33);
    step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      rs1_idx   = 5'($urandom_range(0, 7));
      rs2_idx   = 5'($urandom_range(0, 7));
      rs1_val   = $urandom;
      rs2_val   = $urandom;
      imm       = $urandom;
      alu_src   = 1'($urandom_range(0, 1));
      ctrl_in   = 3'($urandom_range(0, 5));
      rd_in     = 5'($urandom);
      fwd_we    = 1'($urandom_range(0, 1));
      fwd_rd    = 5'($urandom_range(0, 7));
      fwd_data  = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      step();
    end
    idle();
    out_ready = 1;
    repeat (4) step();
    chk("final_drained", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
